// File: rtl/led_pattern_sequencer.sv
// Mode-driven 6-LED pattern sequencer: debounced button cycles COUNT/SCAN/BLINK/OFF, prescaler paces steps.
// Optional PWM dimming of lit LEDs is enabled by defining LED_PWM_DIM_EN.
module led_pattern_sequencer #(
  parameter int TICK_DIV        = 13500000,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_n,
  input  logic       pause,
`ifdef LED_PWM_DIM_EN
  input  logic [7:0] dim,
`endif
  output logic [5:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]    DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    SCAN  = 2'd1,
    BLINK = 2'd2,
    OFF   = 2'd3
  } mode_t;

  logic              sync_p0;
  logic              sync_p1;
  logic [DB_W-1:0]   db_cnt;
  logic              db_level;
  logic              press;

  mode_t             state_q;
  mode_t             state_d;
  logic [5:0]        pattern_q;
  logic [5:0]        pattern_d;
  logic              dir_up_q;
  logic              dir_up_d;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      COUNT:   return SCAN;
      SCAN:    return BLINK;
      BLINK:   return OFF;
      default: return COUNT;
    endcase
  endfunction

  function automatic logic [5:0] start_pattern(input mode_t m);
    return (m == SCAN) ? 6'b000001 : 6'b000000;
  endfunction

  // Returns {dir_up, pattern}; the end bit is shown once before reversing.
  function automatic logic [6:0] scan_step(input logic up, input logic [5:0] p);
    if (up) begin
      if (p[5]) return {1'b0, p >> 1};
      else      return {1'b1, p << 1};
    end else begin
      if (p[0]) return {1'b1, p << 1};
      else      return {1'b0, p >> 1};
    end
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level accepted after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt   <= '0;
      db_level <= 1'b1;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        db_cnt   <= '0;
        db_level <= sync_p1;
        press    <= ~sync_p1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= COUNT;
      pattern_q <= '0;
      dir_up_q  <= 1'b1;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      dir_up_q  <= dir_up_d;
      presc_q   <= presc_d;
    end
  end

  // A press restarts the new mode cleanly, so a coincident tick step is dropped.
  always_comb begin
    tick      = (presc_q == PRESC_MAX) && !pause;
    state_d   = state_q;
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    presc_d   = presc_q;
    if (!pause) presc_d = tick ? '0 : presc_q + 1'b1;
    if (press) begin
      state_d   = next_mode(state_q);
      pattern_d = start_pattern(state_d);
      presc_d   = '0;
      dir_up_d  = 1'b1;
    end else if (tick) begin
      case (state_q)
        COUNT:   pattern_d = pattern_q + 6'd1;
        SCAN:    {dir_up_d, pattern_d} = scan_step(dir_up_q, pattern_q);
        BLINK:   pattern_d = ~pattern_q;
        default: pattern_d = '0;
      endcase
    end
  end

  assign mode = state_q;

`ifdef LED_PWM_DIM_EN
  logic [7:0] pwm_cnt;
  logic [5:0] lit_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign lit_mask = (pwm_cnt < dim) ? 6'h3F : 6'h00;
  assign led      = ~(pattern_q & lit_mask);
`else
  assign led = ~pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed vector table, hand-written corner sequences and
// randomized button/pause stimulus against a behavioural model (LED_PWM_DIM_EN optional).
module tb_led_pattern_sequencer;
  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_n = 1'b1;
  logic       pause = 1'b0;
  logic [5:0] led;
  logic [1:0] mode;
  logic       tick;
`ifdef LED_PWM_DIM_EN
  logic [7:0] dim = 8'd255;
`endif

  led_pattern_sequencer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_n   (btn_n),
    .pause   (pause),
`ifdef LED_PWM_DIM_EN
    .dim     (dim),
`endif
    .led     (led),
    .mode    (mode),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: mode number, counter value, scan phase 0..9, blink flag
  int m_mode, m_cnt, m_phase, m_presc, m_pwm;
  bit m_blink, m_level, m_press;
  bit hist[$];

  typedef struct {
    bit         btn;
    bit         pse;
    int         cycles;
    logic [5:0] exp_led;
    logic [1:0] exp_mode;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pattern();
    int pos;
    pos = (m_phase <= 5) ? m_phase : 10 - m_phase;
    case (m_mode)
      0:       return m_cnt;
      1:       return 1 << pos;
      2:       return m_blink ? 63 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int apply_dim(input int exp);
`ifdef LED_PWM_DIM_EN
    if (!(m_pwm < int'(dim))) return 63;
`endif
    return exp;
  endfunction

  function automatic int model_led();
    return apply_dim((~model_pattern()) & 63);
  endfunction

  function automatic bit model_tick(input bit p);
    return (m_presc == TICK_DIV - 1) && !p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_phase = 0; m_presc = 0; m_pwm = 0;
    m_blink = 0; m_level = 1; m_press = 0;
    hist.delete();
    repeat (DEB + 2) hist.push_back(1'b1);
  endtask

  task automatic model_edge(input bit b, input bit p);
    bit t;
    bit all_diff;
    int s;
    t = model_tick(p);
    if (m_press) begin
      m_mode = (m_mode + 1) % 4;
      m_cnt = 0; m_phase = 0; m_blink = 0; m_presc = 0;
    end else begin
      if (!p) m_presc = (m_presc + 1) % TICK_DIV;
      if (t) begin
        case (m_mode)
          0:       m_cnt = (m_cnt + 1) % 64;
          1:       m_phase = (m_phase + 1) % 10;
          2:       m_blink = !m_blink;
          default: ;
        endcase
      end
    end
    // Button seen through two sync stages must disagree with the level for DEB edges.
    s = hist.size();
    all_diff = 1'b1;
    for (int i = 2; i <= DEB + 1; i++)
      if (hist[s - i] == m_level) all_diff = 1'b0;
    m_press = 1'b0;
    if (all_diff) begin
      m_level = !m_level;
      m_press = !m_level;
    end
    hist.push_back(b);
    if (hist.size() > 32) void'(hist.pop_front());
    m_pwm = (m_pwm + 1) % 256;
  endtask

  // Called at a falling edge: drive, check tick, clock, then check registered outputs.
  task automatic cycle(input bit b, input bit p);
    btn_n = b;
    pause = p;
    #1;
    check("tick", tick, model_tick(p));
    @(posedge clk);
    model_edge(b, p);
    @(negedge clk);
    check("led", led, model_led());
    check("mode", mode, m_mode);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    btn_n = 1'b1;
    pause = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    check("reset led", led, 6'h3F);
    check("reset mode", mode, 2'd0);
    check("reset tick", tick, 1'b0);
  endtask

  task automatic press_release();
    repeat (6) cycle(1'b0, 1'b0);
    repeat (8) cycle(1'b1, 1'b0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit;
    vecs[0]  = '{1'b1, 1'b0, 16,  6'h3B, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 6,   6'h3A, 2'd0};
    vecs[2]  = '{1'b1, 1'b1, 20,  6'h3A, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 234, 6'h3F, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 5,   6'h3E, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1,   6'h3E, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 4,   6'h3D, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 16,  6'h1F, 2'd1};
    vecs[8]  = '{1'b1, 1'b0, 20,  6'h3E, 2'd1};
    vecs[9]  = '{1'b0, 1'b0, 2,   6'h3E, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 10,  6'h37, 2'd1};

    model_reset();
    do_reset();

    foreach (vecs[k]) begin
      repeat (vecs[k].cycles) cycle(vecs[k].btn, vecs[k].pse);
      check($sformatf("vec%0d led", k), led, apply_dim(int'(vecs[k].exp_led)));
      check($sformatf("vec%0d mode", k), mode, vecs[k].exp_mode);
    end

    // SCAN -> BLINK -> OFF
    press_release();
    press_release();
    check("reach off mode", mode, 2'd3);
    check("reach off led", led, 6'h3F);

    // OFF -> COUNT wraps the mode sequence
    repeat (6) cycle(1'b0, 1'b0);
    check("off to count mode", mode, 2'd0);
    check("off to count led", led, 6'h3F);
    repeat (6) cycle(1'b1, 1'b0);
    check("count before coincide", led, apply_dim(6'h3E));

    // Press lands in the same cycle as a tick: press wins, count step dropped
    repeat (5) cycle(1'b0, 1'b0);
    btn_n = 1'b0;
    pause = 1'b0;
    #1;
    check("coincide tick", tick, 1'b1);
    check("coincide pre mode", mode, 2'd0);
    check("coincide pre led", led, apply_dim(6'h3D));
    @(posedge clk);
    model_edge(1'b0, 1'b0);
    @(negedge clk);
    check("coincide mode", mode, 2'd1);
    check("coincide led", led, apply_dim(6'h3E));

    // Asynchronous reset in the middle of SCAN
    repeat (9) cycle(1'b1, 1'b0);
    check("scan before reset", led, apply_dim(6'h3B));
    #3;
    reset_n = 1'b0;
    #1;
    check("async reset led", led, 6'h3F);
    check("async reset mode", mode, 2'd0);
    check("async reset tick", tick, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    check("after reset led", led, 6'h3F);

    // Randomized button levels and pause against the model
    for (int i = 0; i < 3000; ) begin
      bit b;
      bit p;
      int len;
      b = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 9) == 0);
      len = $urandom_range(1, 12);
      repeat (len) cycle(b, p);
      i += len;
    end

`ifdef LED_PWM_DIM_EN
    do_reset();
    repeat (4) cycle(1'b1, 1'b0);
    dim = 8'd64;
    lit = 0;
    repeat (256) begin
      cycle(1'b1, 1'b1);
      if (led[0] == 1'b0) lit++;
    end
    check("pwm dim64 lit cycles", lit, 64);
    dim = 8'd0;
    lit = 0;
    repeat (256) begin
      cycle(1'b1, 1'b1);
      if (led != 6'h3F) lit++;
    end
    check("pwm dim0 lit cycles", lit, 0);
`else
    lit = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
